// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller for the 8x8 block ALU.
// Takes one command at a time and walks the ALU through every pass of every block.
// Each pass waits for the operand buffers and for ALU ready. The read buffers are
// popped once per block, after that block's last pass.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// ISSUE  | flags set up, execute fires when blk_valid && alu_ready
// DRAIN  | ALU busy with the pass, wait for alu_ready to return
// DONE   | command finished, done pulse follows, back to IDLE
module alu_sequencer #(
  parameter int BLK_W      = 16,
  parameter int SUB_BLOCKS = 4,
  parameter int SUB_INDEX  = 64,
  localparam int SB_W = (SUB_BLOCKS > 1) ? $clog2(SUB_BLOCKS) : 1,
  localparam int SI_W = (SUB_INDEX  > 1) ? $clog2(SUB_INDEX)  : 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [BLK_W-1:0] cmd_nblocks,
  input  logic             cmd_rev_mask,
  input  logic             blk_valid,
  output logic             blk_consume,
  input  logic             alu_ready,
  output logic             alu_execute,
  output logic [2:0]       alu_operation,
  output logic [SB_W-1:0]  alu_sub_block,
  output logic [SI_W-1:0]  alu_sub_index,
  output logic             alu_rev_mask,
  output logic             busy,
  output logic             done,
  output logic             err_illegal
);

  localparam int CNT_W = (SI_W > SB_W) ? SI_W : SB_W;

  localparam logic [2:0] OP_POOL_A  = 3'b001;
  localparam logic [2:0] OP_POOL_B  = 3'b010;
  localparam logic [2:0] OP_DOT     = 3'b101;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_rev;
  logic [BLK_W-1:0] r_nblocks;
  logic [BLK_W-1:0] r_blk_cnt;
  logic [CNT_W-1:0] r_pass_cnt;
  logic             r_drain_first;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_consume;
  logic [SB_W-1:0]  r_sub_block;
  logic [SI_W-1:0]  r_sub_index;

  logic             w_is_pool;
  logic             w_is_dot;
  logic             w_last_pass;
  logic             w_last_blk;
  logic             w_fire;
  logic [CNT_W-1:0] w_pass_inc;

  assign w_is_pool  = (r_op == OP_POOL_A) || (r_op == OP_POOL_B);
  assign w_is_dot   = (r_op == OP_DOT);
  assign w_last_blk = (r_blk_cnt == (r_nblocks - BLK_W'(1)));
  assign w_pass_inc = r_pass_cnt + CNT_W'(1);

  // Execute is decided in the ISSUE cycle itself so a pass takes only 3 cycles;
  // reset masks it so an aborted command cannot fire one more pass.
  assign w_fire = (r_state == S_ISSUE) && blk_valid && alu_ready && !iRST;

  // Last-pass detect depends on how many passes the latched opcode needs per block.
  always_comb begin
    w_last_pass = 1'b1;
    if (w_is_pool) begin
      w_last_pass = (r_pass_cnt == CNT_W'(SUB_BLOCKS - 1));
    end else if (w_is_dot) begin
      w_last_pass = (r_pass_cnt == CNT_W'(SUB_INDEX - 1));
    end
  end

  // Sequencer FSM. Flags only change when the FSM enters ISSUE, so they hold
  // steady through the execute cycle and the whole of DRAIN.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_rev         <= 1'b0;
      r_nblocks     <= '0;
      r_blk_cnt     <= '0;
      r_pass_cnt    <= '0;
      r_drain_first <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_consume     <= 1'b0;
      r_sub_block   <= '0;
      r_sub_index   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_consume <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            if (cmd_op == OP_ILLEGAL) begin
              r_err <= 1'b1;
            end else begin
              r_op        <= cmd_op;
              r_rev       <= cmd_rev_mask;
              r_nblocks   <= cmd_nblocks;
              r_blk_cnt   <= '0;
              r_pass_cnt  <= '0;
              r_sub_block <= '0;
              r_sub_index <= '0;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_state     <= (cmd_nblocks == '0) ? S_DONE : S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_fire) begin
            r_drain_first <= 1'b1;
            r_state       <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_drain_first <= 1'b0;
          // First DRAIN cycle is skipped: ready has not dropped yet there.
          if (alu_ready && !r_drain_first) begin
            if (!w_last_pass) begin
              r_pass_cnt  <= w_pass_inc;
              r_sub_block <= w_is_pool ? w_pass_inc[SB_W-1:0] : '0;
              r_sub_index <= w_is_dot  ? w_pass_inc[SI_W-1:0] : '0;
              r_state     <= S_ISSUE;
            end else begin
              r_consume <= 1'b1;
              if (!w_last_blk) begin
                r_pass_cnt  <= '0;
                r_sub_block <= '0;
                r_sub_index <= '0;
                r_blk_cnt   <= r_blk_cnt + BLK_W'(1);
                r_state     <= S_ISSUE;
              end else begin
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign blk_consume   = r_consume;
  assign alu_execute   = w_fire;
  assign alu_operation = r_op;
  assign alu_sub_block = r_sub_block;
  assign alu_sub_index = r_sub_index;
  assign alu_rev_mask  = r_rev;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_illegal   = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a simple ALU ready model and event monitor.
module tb_alu_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'b000;
  logic [15:0] cmd_nblocks = 16'd0;
  logic        cmd_rev_mask = 1'b0;
  logic        blk_valid = 1'b0;
  logic        alu_ready = 1'b1;
  logic        cmd_ready, blk_consume, alu_execute, alu_rev_mask;
  logic        busy, done, err_illegal;
  logic [2:0]  alu_operation;
  logic [1:0]  alu_sub_block;
  logic [5:0]  alu_sub_index;

  int total = 0;
  int bad   = 0;

  alu_sequencer dut (
    .iCLK(iCLK), .iRST(iRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_nblocks(cmd_nblocks), .cmd_rev_mask(cmd_rev_mask),
    .blk_valid(blk_valid), .blk_consume(blk_consume),
    .alu_ready(alu_ready), .alu_execute(alu_execute), .alu_operation(alu_operation),
    .alu_sub_block(alu_sub_block), .alu_sub_index(alu_sub_index),
    .alu_rev_mask(alu_rev_mask), .busy(busy), .done(done), .err_illegal(err_illegal)
  );

  always #5 iCLK = ~iCLK;

  // Monitor (at negedge) plus ALU ready model (updated 2 time units after posedge).
  int   n_cyc = 0;
  int   alu_lat = 1;
  logic ready_hold = 1'b0;
  int   m_low = 0;
  logic m_e;
  int   ex_cyc[$];
  int   ex_sb[$];
  int   ex_si[$];
  int   ex_op[$];
  int   ex_rev[$];
  int   cons_after[$];
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   bad_fire = 0;

  initial forever begin
    @(negedge iCLK);
    n_cyc++;
    m_e = alu_execute;
    if (blk_consume === 1'b1) cons_after.push_back(ex_cyc.size());
    if (alu_execute === 1'b1) begin
      ex_cyc.push_back(n_cyc);
      ex_sb.push_back(int'(alu_sub_block));
      ex_si.push_back(int'(alu_sub_index));
      ex_op.push_back(int'(alu_operation));
      ex_rev.push_back(int'(alu_rev_mask));
      if (!(blk_valid && alu_ready)) bad_fire++;
    end
    if (done === 1'b1) done_cnt++;
    if (err_illegal === 1'b1) err_cnt++;
    @(posedge iCLK);
    #2;
    if (m_e === 1'b1) m_low = alu_lat;
    if (m_low > 0) begin
      alu_ready = 1'b0;
      m_low--;
    end else begin
      alu_ready = !ready_hold;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [15:0] nb, input logic rev);
    cmd_op = op;
    cmd_nblocks = nb;
    cmd_rev_mask = rev;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    ok = (done_cnt != d0);
  endtask

  task automatic wait_ex(input int target, input int budget, output bit ok);
    int k = 0;
    while (ex_cyc.size() < target && k < budget) begin
      tick();
      k++;
    end
    ok = (ex_cyc.size() >= target);
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    @(posedge iCLK); #1;
    @(negedge iCLK);
    total++;
    if ({cmd_ready, busy, done, err_illegal, blk_consume, alu_execute, alu_rev_mask} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000000",
               {cmd_ready, busy, done, err_illegal, blk_consume, alu_execute, alu_rev_mask});
    end
    total++;
    if ({alu_operation, alu_sub_block, alu_sub_index} !== 11'd0) begin
      bad++;
      $display("FAIL reset_fields got=%h want=0", {alu_operation, alu_sub_block, alu_sub_index});
    end
    @(posedge iCLK); #1;
    iRST = 1'b0;
    @(negedge iCLK);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_early got=%b want=0", cmd_ready);
    end
    @(posedge iCLK); #1;
    @(negedge iCLK);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after got=%b want=1", cmd_ready);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_single();
    int e0 = ex_cyc.size();
    int c0 = cons_after.size();
    int d0 = done_cnt;
    bit ok;
    blk_valid = 1'b1;
    send_cmd(3'b011, 16'd2, 1'b0);
    @(negedge iCLK);
    total++;
    if ({busy, cmd_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_busy got busy,ready=%b want=10", {busy, cmd_ready});
    end
    @(posedge iCLK); #1;
    wait_done(d0, 100, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL single_timeout got done=0 want done pulse");
    end
    total++;
    if (ex_cyc.size() !== e0 + 2) begin
      bad++;
      $display("FAIL single_ex_count got=%0d want=%0d", ex_cyc.size() - e0, 2);
    end
    if (ex_cyc.size() >= e0 + 2) begin
      total++;
      if (ex_cyc[e0+1] - ex_cyc[e0] !== 3) begin
        bad++;
        $display("FAIL single_gap got=%0d want=3", ex_cyc[e0+1] - ex_cyc[e0]);
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (ex_sb[e0+i] !== 0 || ex_si[e0+i] !== 0 || ex_op[e0+i] !== 3) begin
          bad++;
          $display("FAIL single_flags pass=%0d got sb=%0d si=%0d op=%0d want 0 0 3",
                   i, ex_sb[e0+i], ex_si[e0+i], ex_op[e0+i]);
        end
      end
    end
    total++;
    if (cons_after.size() !== c0 + 2) begin
      bad++;
      $display("FAIL single_consume_count got=%0d want=2", cons_after.size() - c0);
    end else begin
      total++;
      if (cons_after[c0] !== e0 + 1 || cons_after[c0+1] !== e0 + 2) begin
        bad++;
        $display("FAIL single_consume_order got=%0d,%0d want=%0d,%0d",
                 cons_after[c0] - e0, cons_after[c0+1] - e0, 1, 2);
      end
    end
    total++;
    if ({busy, cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL single_idle got busy,ready=%b want=01", {busy, cmd_ready});
    end
  endtask

  task automatic test_pool();
    int e0 = ex_cyc.size();
    int c0 = cons_after.size();
    int d0 = done_cnt;
    bit ok;
    send_cmd(3'b001, 16'd1, 1'b0);
    wait_done(d0, 100, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL pool_timeout got done=0 want done pulse");
    end
    total++;
    if (ex_cyc.size() !== e0 + 4) begin
      bad++;
      $display("FAIL pool_ex_count got=%0d want=4", ex_cyc.size() - e0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ex_sb[e0+i] !== i || ex_si[e0+i] !== 0) begin
          bad++;
          $display("FAIL pool_flags pass=%0d got sb=%0d si=%0d want sb=%0d si=0",
                   i, ex_sb[e0+i], ex_si[e0+i], i);
        end
      end
    end
    total++;
    if (cons_after.size() !== c0 + 1) begin
      bad++;
      $display("FAIL pool_consume_count got=%0d want=1", cons_after.size() - c0);
    end else begin
      total++;
      if (cons_after[c0] !== e0 + 4) begin
        bad++;
        $display("FAIL pool_consume_order got after %0d executes want 4", cons_after[c0] - e0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0 = ex_cyc.size();
    int c0 = cons_after.size();
    int d0 = done_cnt;
    bit ok;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready got=%b want=1", cmd_ready);
    end
    send_cmd(3'b010, 16'd2, 1'b0);
    wait_done(d0, 150, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_timeout got done=0 want done pulse");
    end
    total++;
    if (ex_cyc.size() !== e0 + 8) begin
      bad++;
      $display("FAIL b2b_ex_count got=%0d want=8", ex_cyc.size() - e0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (ex_sb[e0+i] !== (i % 4) || ex_op[e0+i] !== 2) begin
          bad++;
          $display("FAIL b2b_flags pass=%0d got sb=%0d op=%0d want sb=%0d op=2",
                   i, ex_sb[e0+i], ex_op[e0+i], i % 4);
        end
      end
    end
    total++;
    if (cons_after.size() !== c0 + 2) begin
      bad++;
      $display("FAIL b2b_consume_count got=%0d want=2", cons_after.size() - c0);
    end else begin
      total++;
      if (cons_after[c0] !== e0 + 4 || cons_after[c0+1] !== e0 + 8) begin
        bad++;
        $display("FAIL b2b_consume_order got=%0d,%0d want=4,8",
                 cons_after[c0] - e0, cons_after[c0+1] - e0);
      end
    end
  endtask

  task automatic test_dot();
    int e0 = ex_cyc.size();
    int c0 = cons_after.size();
    int d0 = done_cnt;
    bit ok;
    send_cmd(3'b101, 16'd1, 1'b0);
    wait_done(d0, 400, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL dot_timeout got done=0 want done pulse");
    end
    total++;
    if (ex_cyc.size() !== e0 + 64) begin
      bad++;
      $display("FAIL dot_ex_count got=%0d want=64", ex_cyc.size() - e0);
    end else begin
      for (int i = 0; i < 64; i++) begin
        total++;
        if (ex_si[e0+i] !== i || ex_sb[e0+i] !== 0) begin
          bad++;
          $display("FAIL dot_flags pass=%0d got si=%0d sb=%0d want si=%0d sb=0",
                   i, ex_si[e0+i], ex_sb[e0+i], i);
        end
      end
    end
    total++;
    if (cons_after.size() !== c0 + 1) begin
      bad++;
      $display("FAIL dot_consume_count got=%0d want=1", cons_after.size() - c0);
    end else begin
      total++;
      if (cons_after[c0] !== e0 + 64) begin
        bad++;
        $display("FAIL dot_consume_order got after %0d executes want 64", cons_after[c0] - e0);
      end
    end
  endtask

  task automatic test_rev_mask();
    int e0 = ex_cyc.size();
    int d0 = done_cnt;
    bit ok;
    send_cmd(3'b000, 16'd1, 1'b1);
    wait_done(d0, 50, ok);
    total++;
    if (ok !== 1'b1 || ex_cyc.size() !== e0 + 1) begin
      bad++;
      $display("FAIL rev_count got done=%0d ex=%0d want done=1 ex=1", ok, ex_cyc.size() - e0);
    end else begin
      total++;
      if (ex_rev[e0] !== 1 || ex_op[e0] !== 0) begin
        bad++;
        $display("FAIL rev_flags got rev=%0d op=%0d want rev=1 op=0", ex_rev[e0], ex_op[e0]);
      end
    end
  endtask

  task automatic test_stall();
    int e0 = ex_cyc.size();
    int c0 = cons_after.size();
    int d0 = done_cnt;
    int f0 = bad_fire;
    bit ok;
    blk_valid = 1'b0;
    ready_hold = 1'b1;
    send_cmd(3'b001, 16'd1, 1'b0);
    tick(5);
    blk_valid = 1'b1;
    tick(4);
    total++;
    if (ex_cyc.size() !== e0) begin
      bad++;
      $display("FAIL stall_withheld got=%0d executes want=0", ex_cyc.size() - e0);
    end
    ready_hold = 1'b0;
    alu_lat = 5;
    wait_ex(e0 + 2, 100, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL stall_ex_timeout got=%0d executes want=2", ex_cyc.size() - e0);
    end
    blk_valid = 1'b0;
    tick(12);
    total++;
    if (ex_cyc.size() !== e0 + 2) begin
      bad++;
      $display("FAIL stall_blk_drop got=%0d executes want=2", ex_cyc.size() - e0);
    end
    blk_valid = 1'b1;
    wait_done(d0, 200, ok);
    alu_lat = 1;
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL stall_timeout got done=0 want done pulse");
    end
    total++;
    if (ex_cyc.size() !== e0 + 4) begin
      bad++;
      $display("FAIL stall_ex_count got=%0d want=4", ex_cyc.size() - e0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ex_sb[e0+i] !== i) begin
          bad++;
          $display("FAIL stall_flags pass=%0d got sb=%0d want sb=%0d", i, ex_sb[e0+i], i);
        end
      end
      total++;
      if (ex_cyc[e0+1] - ex_cyc[e0] !== 7) begin
        bad++;
        $display("FAIL stall_gap got=%0d want=7", ex_cyc[e0+1] - ex_cyc[e0]);
      end
    end
    total++;
    if (bad_fire !== f0) begin
      bad++;
      $display("FAIL stall_fire_guard got=%0d unqualified executes want=0", bad_fire - f0);
    end
    total++;
    if (cons_after.size() !== c0 + 1) begin
      bad++;
      $display("FAIL stall_consume_count got=%0d want=1", cons_after.size() - c0);
    end
  endtask

  task automatic test_illegal();
    int e0 = ex_cyc.size();
    int r0 = err_cnt;
    int d0 = done_cnt;
    send_cmd(3'b111, 16'd3, 1'b0);
    @(negedge iCLK);
    total++;
    if ({err_illegal, busy} !== 2'b10) begin
      bad++;
      $display("FAIL illegal_pulse got err,busy=%b want=10", {err_illegal, busy});
    end
    @(posedge iCLK); #1;
    tick(10);
    total++;
    if (ex_cyc.size() !== e0 || err_cnt !== r0 + 1 || done_cnt !== d0) begin
      bad++;
      $display("FAIL illegal_effects got ex=%0d err=%0d done=%0d want 0 1 0",
               ex_cyc.size() - e0, err_cnt - r0, done_cnt - d0);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL illegal_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_zero_blocks();
    int e0 = ex_cyc.size();
    int c0 = cons_after.size();
    int d0 = done_cnt;
    bit ok;
    send_cmd(3'b011, 16'd0, 1'b0);
    wait_done(d0, 20, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL zero_timeout got done=0 want done pulse");
    end
    total++;
    if (ex_cyc.size() !== e0 || cons_after.size() !== c0) begin
      bad++;
      $display("FAIL zero_activity got ex=%0d consume=%0d want 0 0",
               ex_cyc.size() - e0, cons_after.size() - c0);
    end
  endtask

  task automatic test_reset_mid();
    int e0 = ex_cyc.size();
    int e1, c1, d1;
    bit ok;
    send_cmd(3'b101, 16'd1, 1'b0);
    wait_ex(e0 + 10, 100, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ex_timeout got=%0d executes want=10", ex_cyc.size() - e0);
    end
    iRST = 1'b1;
    e1 = ex_cyc.size();
    c1 = cons_after.size();
    d1 = done_cnt;
    tick(2);
    iRST = 1'b0;
    tick(100);
    total++;
    if (ex_cyc.size() !== e1 || cons_after.size() !== c1 || done_cnt !== d1) begin
      bad++;
      $display("FAIL rstmid_abort got ex=%0d consume=%0d done=%0d want 0 0 0",
               ex_cyc.size() - e1, cons_after.size() - c1, done_cnt - d1);
    end
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_idle got ready,busy=%b want=10", {cmd_ready, busy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got time limit want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_pool();
    test_back_to_back();
    test_dot();
    test_rev_mask();
    test_stall();
    test_illegal();
    test_zero_blocks();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
